// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latq_rf.sv
// Latch-based register file: DEPTH x WIDTH words, registered write request, gated word latches, async read.
// Optional parity bit per word and PERR output when LATQ_RF_PARITY_EN is defined.
module gf180mcu_fd_sc_mcu9t5v0__latq_rf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    RA,
  output logic [WIDTH-1:0] Q
`ifdef LATQ_RF_PARITY_EN
  ,
  output logic             PERR
`endif
);

  logic             we_q;
  logic [AW-1:0]    wa_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] d_l;
  logic [WIDTH-1:0] rd [DEPTH];
`ifdef LATQ_RF_PARITY_EN
  logic             par_l;
  logic             rd_p [DEPTH];
`endif

  // Stage 1: request flops
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      we_q <= 1'b0;
      wa_q <= '0;
      d_q  <= '0;
    end else begin
      we_q <= WE;
      if (WE) begin
        wa_q <= WA;
        d_q  <= D;
      end
    end
  end

  // Stage 2: low-phase data latch keeps write data stable while the word latch is open,
  // even if a back-to-back request reloads d_q on the same rising edge.
  always_latch begin
    if (RST)       d_l <= '0;
    else if (!CLK) d_l <= d_q;
  end

`ifdef LATQ_RF_PARITY_EN
  always_latch begin
    if (RST)       par_l <= 1'b0;
    else if (!CLK) par_l <= ^d_q;
  end
`endif

  // Storage: per-word enable latch, clock gate and word latch
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic             en_l;
    logic             g;
    logic [WIDTH-1:0] data;

    always_latch begin
      if (RST)       en_l <= 1'b0;
      else if (!CLK) en_l <= we_q && (wa_q == AW'(i));
    end

    assign g = CLK & en_l;

    always_latch begin
      if (RST)    data <= '0;
      else if (g) data <= d_l;
    end

    assign rd[i] = data;

`ifdef LATQ_RF_PARITY_EN
    logic par;

    always_latch begin
      if (RST)    par <= 1'b0;
      else if (g) par <= par_l;
    end

    assign rd_p[i] = par;
`endif
  end

  // Read: out-of-range addresses match no word and return zero
  always_comb begin
    Q = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RA == AW'(i)) Q = rd[i];
    end
  end

`ifdef LATQ_RF_PARITY_EN
  always_comb begin
    PERR = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RA == AW'(i)) PERR = ^{rd[i], rd_p[i]};
    end
  end
`endif

endmodule
